// File: rtl/rng_pkg.sv
// Shared constants for the xorshift128 generator family: default core seeds,
// shift amounts and FSM state encoding.
package rng_pkg;

  localparam logic [31:0] SEED_X = 32'd123456789;
  localparam logic [31:0] SEED_Y = 32'd362436069;
  localparam logic [31:0] SEED_Z = 32'd521288629;
  localparam logic [31:0] SEED_W = 32'd88675123;

  localparam int SHIFT_A = 11;
  localparam int SHIFT_B = 19;
  localparam int SHIFT_C = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    GEN  = ST_GEN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/xorshift128_wide_if.sv
// Request/result bundle of the wide xorshift generator; all strobes active-low.
interface xorshift128_wide_if #(
  parameter int NWORDS = 4
) ();

  localparam int WIDTH = 32 * NWORDS;

  logic             start_n;
  logic             prime_n;
  logic             seed_we_n;
  logic [31:0]      seed;
  logic [WIDTH-1:0] random;
  logic             ready_n;

  modport master (
    output start_n,
    output prime_n,
    output seed_we_n,
    output seed,
    input  random,
    input  ready_n
  );

  modport slave (
    input  start_n,
    input  prime_n,
    input  seed_we_n,
    input  seed,
    output random,
    output ready_n
  );

endinterface

// File: rtl/xorshift128_core.sv
// Marsaglia xorshift128 core: 4x32 state, one step per enabled cycle.
// step_word is the value w will take after the step.
module xorshift128_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] step_word
);
  import rng_pkg::*;

  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] z;
  logic [31:0] w;
  logic [31:0] t;

  always_comb begin
    t         = x ^ (x << SHIFT_A);
    step_word = w ^ (w >> SHIFT_B) ^ t ^ (t >> SHIFT_C);
  end

  // Reseeding restores x/y/z to nonzero constants so a zero seed cannot lock the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= SEED_X;
      y <= SEED_Y;
      z <= SEED_Z;
      w <= SEED_W;
    end else if (load) begin
      x <= SEED_X;
      y <= SEED_Y;
      z <= SEED_Z;
      w <= seed;
    end else if (step) begin
      x <= y;
      y <= z;
      z <= w;
      w <= step_word;
    end
  end

endmodule

// File: rtl/xorshift128_wide.sv
// Wide xorshift128 generator: chains NWORDS core steps into one WIDTH-bit word,
// optionally forcing the top two bits and the LSB for RSA prime candidates.
module xorshift128_wide #(
  parameter int NWORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  xorshift128_wide_if.slave  bus
);
  import rng_pkg::*;

  localparam int WIDTH = 32 * NWORDS;
  localparam int CW = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic             prime_q;
  logic             ready_q;
  logic [WIDTH-1:0] random_q;
  logic [WIDTH-1:0] random_next;
  logic [31:0]      step_word;
  logic             idle_like;
  logic             accept;
  logic             load;
  logic             step;
  logic             last;

  xorshift128_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (step),
    .load      (load),
    .seed      (bus.seed),
    .step_word (step_word)
  );

  // A seed strobe outranks a simultaneous start; both are ignored mid-generation.
  always_comb begin
    idle_like  = (state != GEN);
    load       = idle_like && !bus.seed_we_n;
    accept     = idle_like && !bus.start_n && bus.seed_we_n;
    step       = (state == GEN);
    last       = step && (cnt == LAST_CNT);

    state_next = state;
    case (state)
      IDLE, DONE: if (accept) state_next = GEN;
      GEN:        if (last) state_next = DONE;
      default:    state_next = IDLE;
    endcase

    random_next = random_q;
    for (int i = 0; i < NWORDS; i++) begin
      if (step && (cnt == CW'(i))) random_next[32*i +: 32] = step_word;
    end
    if (last && prime_q) begin
      random_next[WIDTH-1] = 1'b1;
      random_next[WIDTH-2] = 1'b1;
      random_next[0]       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      prime_q  <= 1'b0;
      ready_q  <= 1'b1;
      random_q <= '0;
    end else begin
      state    <= state_next;
      random_q <= random_next;
      if (accept) begin
        cnt     <= '0;
        prime_q <= ~bus.prime_n;
        ready_q <= 1'b1;
      end else if (step) begin
        cnt <= cnt + CW'(1);
        if (last) ready_q <= 1'b0;
      end
    end
  end

  assign bus.random  = random_q;
  assign bus.ready_n = ready_q;

endmodule

// File: doc/xorshift128_wide.md
Name: xorshift128_wide

Overview:
- Parametrised successor to the 32-bit xorshift generator.
- Runs a Marsaglia xorshift128 core, one 32-bit step per cycle, and assembles NWORDS steps into one WIDTH-bit random word.
- Supports reseeding and an RSA prime-candidate mode that forces the top two bits and the LSB to 1.
- Feeds the key-generation path: prime candidate search and blinding values for modular exponentiation.

Parameters:
- NWORDS, 4, number of 32-bit steps per result (legal range 1..32).
- WIDTH, 32*NWORDS, result width. Derived; never overridden independently.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_n  in  1  active-low request for a new random word.
- prime_n  in  1  active-low prime-candidate mode. Sampled with the accepted start_n.
- seed_we_n  in  1  active-low seed load strobe.
- seed  in  32  seed value, loaded into core word w.
- random  out  WIDTH  result word. Word 0 occupies bits [31:0].
- ready_n  out  1  active-low: random is valid and the block is idle.

Behaviour:
- Reset (async, rst_n=0):
  - Core state: x=32'd123456789, y=32'd362436069, z=32'd521288629, w=32'd88675123.
  - random=0, ready_n=1, state=IDLE, cnt=0, prime_q=0.
- Core step (one per GEN cycle):
  - t = x ^ (x<<11); x<=y; y<=z; z<=w.
  - w <= w ^ (w>>19) ^ t ^ (t>>8). All shifts are logical, 32-bit.
  - Step output = new w.
- FSM states: IDLE, GEN, DONE.
  - IDLE: start_n=0 and seed_we_n=1 -> GEN. Same edge: cnt<=0, prime_q<=~prime_n, ready_n<=1.
  - GEN: each cycle steps the core and writes the step output into random[32*cnt+:32], then cnt<=cnt+1. When cnt==NWORDS-1, that write is the last one; next state is DONE.
  - Prime mode: on the final GEN write, if prime_q, bits WIDTH-1, WIDTH-2 and 0 of random are forced to 1. For NWORDS=1 this applies to the same word.
  - DONE: ready_n=0 and random is held stable. start_n=0 (with seed_we_n=1) -> GEN, with the same actions as from IDLE; ready_n rises on that edge.
- Latency: start_n sampled low at edge E -> ready_n low after edge E+NWORDS. Each result costs NWORDS+1 clock edges.
- start_n is level-sampled. Holding it low in DONE starts back-to-back generations, one result every NWORDS+1 cycles.
- start_n and seed_we_n are ignored while in GEN. prime_n is sampled only at start acceptance.
- Seed load (seed_we_n=0 in IDLE or DONE):
  - x, y, z take their reset constants; w<=seed.
  - random, ready_n and state are unchanged.
  - seed=0 is legal; x, y, z are nonzero, so the core never locks up.
- seed_we_n=0 and start_n=0 in the same cycle: the seed load wins and start is dropped. The requester must re-assert start_n.
- Reset mid-GEN: immediate return to reset values; the partial word is discarded.
- random bits not yet written in the current generation keep their previous contents. They are don't-care until ready_n=0.

Decomposition:
- Shared package rng_pkg holds:
  - the four xorshift128 default seed constants;
  - shift amounts 11/19/8;
  - state encoding localparams for IDLE/GEN/DONE.
- Sub-module xorshift128_core holds the 4x32 state, the step enable, the seed load and the 32-bit step output.
- Top level owns the FSM, cnt (width $clog2(NWORDS+1)), the result register and prime forcing.

Test Plan:
- NWORDS=1, reset, start_n pulsed low for 1 cycle -> ready_n low 1 cycle after the GEN edge; random=32'hDCA345EA. Second start -> random=32'h1B5116E6.
- NWORDS=2, one start -> random=64'h1B5116E6_DCA345EA; ready_n asserted exactly 2 edges after acceptance.
- NWORDS=1, prime_n=0 at start -> random=32'hDCA345EB. NWORDS=4 -> bits 127, 126 and 0 are all 1; the remaining bits match the bit-accurate reference model.
- Load seed 32'h0 then start (NWORDS=1) -> matches the model seeded with w=0; output is nonzero. start_n toggled during GEN -> no extra generation and no change in cadence.
- rst_n dropped in the 2nd GEN cycle (NWORDS=4) -> random=0 and ready_n=1 immediately. After release, a start gives 0xDCA345EA in word 0.
- seed_we_n and start_n low together in IDLE -> seed loaded, ready_n stays 1, no GEN entered. start_n held low in DONE -> continuous results every NWORDS+1 cycles, all matching the model.
